reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side master for the 8x16 general register file.
- Accepts results from two producers, the ALU and the load unit, over valid/ready handshakes.
- Buffers load results in a small FIFO and arbitrates between the two sources.
- Drives the register file write port (write enable, destination, data) with exactly one write per cycle at most.
- Keeps a pending-destination scoreboard so issue logic can detect read-after-write hazards.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register index width; NREG = 2**ADDR_W = 8
- LQ_DEPTH, 2, load-result FIFO depth (power of two, >= 2)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- issue_valid  in  1  instruction with register destination issued this cycle
- issue_dest  in  ADDR_W  destination of the issued instruction
- alu_valid  in  1  ALU result valid
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted when alu_valid & alu_ready
- ld_valid  in  1  load result valid
- ld_dest  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- ld_ready  out  1  load result accepted when ld_valid & ld_ready
- reg_write_en  out  1  register file write enable (registered)
- reg_write_dest  out  ADDR_W  register file write index (registered)
- reg_write_data  out  DATA_W  register file write data (registered)
- pending  out  NREG  bit d = 1: a write to register d is outstanding
- busy  out  1  FIFO non-empty or reg_write_en high

Behaviour:

Reset:
- Asynchronous assertion; synchronous release on first clk edge with rst=1.
- While in reset: reg_write_en=0, reg_write_dest=0, reg_write_data=0, pending=0, FIFO empty, busy=0.
- Reset mid-operation discards queued loads and all pending bits; no write is issued after release until new handshakes occur.

Load FIFO:
- Capacity LQ_DEPTH entries, each {dest, data}.
- ld_ready = !full, computed from registered state only; there is no same-cycle pop look-ahead.
- Push on ld_valid & ld_ready.
- Pointers wrap modulo LQ_DEPTH; full/empty are tracked with an extra pointer bit.
- Push and pop in the same cycle are legal when neither full nor empty prevents them.

Arbitration (per cycle, combinational select; result registered):
- 1) FIFO full: pop the FIFO head; alu_ready=0.
- 2) Otherwise, if alu_valid: take the ALU result; alu_ready=1.
- 3) Otherwise, if the FIFO is non-empty: pop the head.
- 4) Otherwise: no write.
- alu_ready = !full, independent of alu_valid.
- A load pushed in cycle N cannot be popped in cycle N.

Write output:
- At the edge ending a cycle with a selected source: reg_write_en<=1, and dest/data are loaded from the selected source.
- Otherwise reg_write_en<=0, and dest/data hold their last values.

Latency:
- ALU: handshake in cycle N gives reg_write_en=1 in cycle N+1.
- Load with idle ALU and empty FIFO: handshake in cycle N gives a write in cycle N+2.

Ordering:
- Loads are written in acceptance order.
- No ordering is guaranteed between ALU and load results. Issue logic must not have two outstanding writes to the same destination; this is not checked.

Scoreboard:
- At each edge: pending[issue_dest] is set if issue_valid.
- At each edge: pending[reg_write_dest] is cleared if reg_write_en is currently 1.
- If set and clear target the same index in the same cycle, set wins.
- Register 0 has no special treatment.

busy:
- Registered-state function: (FIFO non-empty) | reg_write_en.

Test Plan:
- Reset release, then a single ALU result alu_dest=3, alu_data=16'h1234 in cycle 1 -> cycle 2: reg_write_en=1, dest=3, data=16'h1234; cycle 3: reg_write_en=0.
- A single load ld_dest=5, data=16'hBEEF with ALU idle -> ld_ready=1 throughout; write of 5/16'hBEEF appears exactly 2 cycles after the handshake.
- ALU valid every cycle (dests 1,2,3,...) while three loads arrive back-to-back -> FIFO fills after 2 loads; ld_ready=0; the next cycle pops a load and alu_ready=0; all 3 loads are written in order; no ALU result is lost or duplicated.
- issue_valid with dest=4 -> pending=8'h10 next cycle; ALU write to 4 -> pending[4] clears the cycle after reg_write_en is seen. Same-cycle issue of dest 4 while write of 4 is active -> pending[4] stays 1.
- Two loads queued (FIFO full), then rst pulsed low mid-cycle (async) -> outputs 0 immediately; after release, no write occurs, busy=0, ld_ready=1.
- Random ALU/load traffic for 10k cycles against a reference model -> every accepted result is written exactly once with the correct dest/data; at most one write per cycle; load order is preserved.

Source files
------------

// File: rtl/reg_writeback_if.sv
// Result/writeback bundle: issue notify, ALU and load result handshakes,
// register-file write port, pending-destination scoreboard and busy flag.
//   master: result producers / issue logic / register file side
//   slave : reg_writeback (consumes results, drives the write port)
interface reg_writeback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    localparam int NREG = 2 ** ADDR_W;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dest;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_dest;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;

    logic [NREG-1:0]   pending;
    logic              busy;

    modport master (
        output issue_valid, issue_dest,
        output alu_valid, alu_dest, alu_data,
        output ld_valid, ld_dest, ld_data,
        input  alu_ready, ld_ready,
        input  reg_write_en, reg_write_dest, reg_write_data,
        input  pending, busy
    );

    modport slave (
        input  issue_valid, issue_dest,
        input  alu_valid, alu_dest, alu_data,
        input  ld_valid, ld_dest, ld_data,
        output alu_ready, ld_ready,
        output reg_write_en, reg_write_dest, reg_write_data,
        output pending, busy
    );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write master: merges ALU results and FIFO-buffered load
// results onto one registered write port and tracks pending destinations.
// Ports: clk, rst (async active-low), wb (reg_writeback_if.slave):
//   issue_valid/dest in; alu_* and ld_* valid/ready in; reg_write_* out;
//   pending[NREG] out; busy out.
module reg_writeback #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int LQ_DEPTH = 2
) (
    input logic            clk,
    input logic            rst,
    reg_writeback_if.slave wb
);
    localparam int NREG  = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [ENT_W-1:0]  mem_q [LQ_DEPTH];
    logic [ENT_W-1:0]  mem_d [LQ_DEPTH];
    logic [PTR_W:0]    wptr_q, wptr_d;
    logic [PTR_W:0]    rptr_q, rptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NREG-1:0]   pending_q, pending_d;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              take_alu;
    logic [ENT_W-1:0]  head;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign head  = mem_q[rptr_q[PTR_W-1:0]];

    // A full queue steals the port so loads cannot starve forever;
    // otherwise the ALU wins and the queue drains on idle ALU cycles.
    assign push     = wb.ld_valid & ~full;
    assign take_alu = ~full & wb.alu_valid;
    assign pop      = full | (~wb.alu_valid & ~empty);

    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        we_d      = 1'b0;
        dest_d    = dest_q;
        data_d    = data_q;
        pending_d = pending_q;

        if (push) begin
            mem_d[wptr_q[PTR_W-1:0]] = {wb.ld_dest, wb.ld_data};
            wptr_d = wptr_q + PTR_ONE;
        end

        unique case (1'b1)
            pop: begin
                we_d             = 1'b1;
                {dest_d, data_d} = head;
                rptr_d           = rptr_q + PTR_ONE;
            end
            take_alu: begin
                we_d   = 1'b1;
                dest_d = wb.alu_dest;
                data_d = wb.alu_data;
            end
            default: ;
        endcase

        // Clear first so a same-cycle issue to the same index wins.
        if (we_q) begin
            pending_d[dest_q] = 1'b0;
        end
        if (wb.issue_valid) begin
            pending_d[wb.issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q     <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            we_q      <= 1'b0;
            dest_q    <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            we_q      <= we_d;
            dest_q    <= dest_d;
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    assign wb.alu_ready      = ~full;
    assign wb.ld_ready       = ~full;
    assign wb.reg_write_en   = we_q;
    assign wb.reg_write_dest = dest_q;
    assign wb.reg_write_data = data_q;
    assign wb.pending        = pending_q;
    assign wb.busy           = ~empty | we_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus
// a queue scoreboard matching every register write to an accepted result.
module tb_reg_writeback;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    reg_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    reg_writeback #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LQ_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb(wb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    ent_t alu_q[$];
    ent_t ld_q[$];

    always @(negedge clk) begin : scoreboard
        ent_t got;
        if (!rst) begin
            alu_q.delete();
            ld_q.delete();
        end else begin
            if (wb.reg_write_en) begin
                got = {wb.reg_write_dest, wb.reg_write_data};
                n_checks++;
                if (alu_q.size() > 0 && alu_q[0] == got) begin
                    void'(alu_q.pop_front());
                end else if (ld_q.size() > 0 && ld_q[0] == got) begin
                    void'(ld_q.pop_front());
                end else begin
                    n_fail++;
                    $display("FAIL sb_write: got dest=%0d data=%h, required head of alu(%0d) or ld(%0d) queue",
                             got.dest, got.data, alu_q.size(), ld_q.size());
                end
            end
            if (wb.alu_valid && wb.alu_ready)
                alu_q.push_back({wb.alu_dest, wb.alu_data});
            if (wb.ld_valid && wb.ld_ready)
                ld_q.push_back({wb.ld_dest, wb.ld_data});
        end
    end

    task automatic idle();
        wb.issue_valid = 1'b0;
        wb.issue_dest  = '0;
        wb.alu_valid   = 1'b0;
        wb.alu_dest    = '0;
        wb.alu_data    = '0;
        wb.ld_valid    = 1'b0;
        wb.ld_dest     = '0;
        wb.ld_data     = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (wb.reg_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_we: got %b required 0", wb.reg_write_en);
        end
        n_checks++;
        if (wb.reg_write_dest !== '0 || wb.reg_write_data !== '0) begin
            n_fail++;
            $display("FAIL reset_dd: got %0d/%h required 0/0000",
                     wb.reg_write_dest, wb.reg_write_data);
        end
        n_checks++;
        if (wb.pending !== 8'h00 || wb.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pb: got pending=%h busy=%b required 00/0",
                     wb.pending, wb.busy);
        end
        n_checks++;
        if (wb.ld_ready !== 1'b1 || wb.alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rdy: got ld=%b alu=%b required 1/1",
                     wb.ld_ready, wb.alu_ready);
        end
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_alu();
        cyc();
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 3'd3;
        wb.alu_data  = 16'h1234;
        @(negedge clk);
        n_checks++;
        if (wb.alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_ready: got %b required 1", wb.alu_ready);
        end
        cyc();
        idle();
        @(negedge clk);
        n_checks++;
        if (wb.reg_write_en !== 1'b1 || wb.reg_write_dest !== 3'd3 ||
            wb.reg_write_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL alu_write: got en=%b %0d/%h required 1 3/1234",
                     wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (wb.reg_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_we_off: got %b required 0", wb.reg_write_en);
        end
    endtask

    task automatic test_load();
        cyc();
        wb.ld_valid = 1'b1;
        wb.ld_dest  = 3'd5;
        wb.ld_data  = 16'hBEEF;
        @(negedge clk);
        n_checks++;
        if (wb.ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_ready_hs: got %b required 1", wb.ld_ready);
        end
        cyc();
        idle();
        @(negedge clk);
        n_checks++;
        if (wb.reg_write_en !== 1'b0 || wb.ld_ready !== 1'b1 ||
            wb.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_n1: got en=%b rdy=%b busy=%b required 0 1 1",
                     wb.reg_write_en, wb.ld_ready, wb.busy);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (wb.reg_write_en !== 1'b1 || wb.reg_write_dest !== 3'd5 ||
            wb.reg_write_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL ld_write: got en=%b %0d/%h required 1 5/beef",
                     wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (wb.reg_write_en !== 1'b0 || wb.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_done: got en=%b busy=%b required 0 0",
                     wb.reg_write_en, wb.busy);
        end
    endtask

    task automatic test_back_to_back();
        int ai = 0;
        int li = 0;
        int full_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            cyc();
            wb.alu_valid = (c < 10);
            wb.alu_dest  = 3'((ai % 7) + 1);
            wb.alu_data  = 16'h0100 + 16'(ai);
            wb.ld_valid  = (li < 3);
            wb.ld_dest   = 3'(5 + li);
            wb.ld_data   = 16'hC001 + 16'(li);
            @(negedge clk);
            if (full_cyc < 0 && wb.ld_valid && !wb.ld_ready) begin
                full_cyc = c;
                n_checks++;
                if (wb.alu_ready !== 1'b0 || li != 2) begin
                    n_fail++;
                    $display("FAIL b2b_full: got alu_ready=%b loads=%0d required 0/2",
                             wb.alu_ready, li);
                end
            end else if (full_cyc >= 0 && c == full_cyc + 1) begin
                n_checks++;
                if (wb.reg_write_en !== 1'b1 || wb.reg_write_dest !== 3'd5 ||
                    wb.reg_write_data !== 16'hC001) begin
                    n_fail++;
                    $display("FAIL b2b_pop: got en=%b %0d/%h required 1 5/c001",
                             wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data);
                end
            end
            if (wb.alu_valid && wb.alu_ready) ai++;
            if (wb.ld_valid && wb.ld_ready) li++;
        end
        idle();
        repeat (6) cyc();
        @(negedge clk);
        n_checks++;
        if (full_cyc != 2 || ai != 8 || li != 3) begin
            n_fail++;
            $display("FAIL b2b_counts: got full_cyc=%0d alu=%0d ld=%0d required 2/8/3",
                     full_cyc, ai, li);
        end
        n_checks++;
        if (alu_q.size() != 0 || ld_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got alu_q=%0d ld_q=%0d required 0/0",
                     alu_q.size(), ld_q.size());
        end
    endtask

    task automatic test_pending();
        cyc();
        wb.issue_valid = 1'b1;
        wb.issue_dest  = 3'd4;
        @(negedge clk);
        n_checks++;
        if (wb.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL pend_pre: got %h required 00", wb.pending);
        end
        cyc();
        idle();
        @(negedge clk);
        n_checks++;
        if (wb.pending !== 8'h10) begin
            n_fail++;
            $display("FAIL pend_set: got %h required 10", wb.pending);
        end
        cyc();
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 3'd4;
        wb.alu_data  = 16'h0444;
        cyc();
        idle();
        @(negedge clk);
        n_checks++;
        if (wb.reg_write_en !== 1'b1 || wb.reg_write_dest !== 3'd4 ||
            wb.pending !== 8'h10) begin
            n_fail++;
            $display("FAIL pend_wr: got en=%b dest=%0d pending=%h required 1 4 10",
                     wb.reg_write_en, wb.reg_write_dest, wb.pending);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (wb.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL pend_clr: got %h required 00", wb.pending);
        end
        cyc();
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 3'd4;
        wb.alu_data  = 16'h0445;
        cyc();
        idle();
        wb.issue_valid = 1'b1;
        wb.issue_dest  = 3'd4;
        @(negedge clk);
        n_checks++;
        if (wb.reg_write_en !== 1'b1 || wb.reg_write_dest !== 3'd4) begin
            n_fail++;
            $display("FAIL pend_same_wr: got en=%b dest=%0d required 1 4",
                     wb.reg_write_en, wb.reg_write_dest);
        end
        cyc();
        idle();
        @(negedge clk);
        n_checks++;
        if (wb.pending !== 8'h10) begin
            n_fail++;
            $display("FAIL pend_set_wins: got %h required 10", wb.pending);
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 3'd6;
        wb.alu_data  = 16'h0600;
        wb.ld_valid  = 1'b1;
        wb.ld_dest   = 3'd1;
        wb.ld_data   = 16'h8001;
        cyc();
        wb.alu_data  = 16'h0601;
        wb.ld_dest   = 3'd2;
        wb.ld_data   = 16'h8002;
        cyc();
        idle();
        #2;
        n_checks++;
        if (wb.ld_ready !== 1'b0 || wb.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_full: got ld_ready=%b busy=%b required 0 1",
                     wb.ld_ready, wb.busy);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (wb.reg_write_en !== 1'b0 || wb.reg_write_dest !== '0 ||
            wb.reg_write_data !== '0) begin
            n_fail++;
            $display("FAIL rmid_wr: got en=%b %0d/%h required 0 0/0000",
                     wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data);
        end
        n_checks++;
        if (wb.pending !== 8'h00 || wb.busy !== 1'b0 || wb.ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_st: got pending=%h busy=%b ld_ready=%b required 00 0 1",
                     wb.pending, wb.busy, wb.ld_ready);
        end
        cyc();
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (wb.reg_write_en !== 1'b0 || wb.busy !== 1'b0 ||
                wb.ld_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rmid_post%0d: got en=%b busy=%b ld_ready=%b required 0 0 1",
                         i, wb.reg_write_en, wb.busy, wb.ld_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] cnt = '0;
        bit alu_hs = 1'b0;
        bit ld_hs  = 1'b0;
        int n_acc  = 0;
        for (int i = 0; i < 10000; i++) begin
            cyc();
            if (!wb.alu_valid || alu_hs) begin
                wb.alu_valid = ($urandom_range(0, 99) < 50);
                wb.alu_dest  = 3'($urandom());
                wb.alu_data  = {1'b0, cnt[14:0]};
                cnt++;
            end
            if (!wb.ld_valid || ld_hs) begin
                wb.ld_valid = ($urandom_range(0, 99) < 35);
                wb.ld_dest  = 3'($urandom());
                wb.ld_data  = {1'b1, cnt[14:0]};
                cnt++;
            end
            wb.issue_valid = 1'($urandom_range(0, 1));
            wb.issue_dest  = 3'($urandom());
            @(negedge clk);
            alu_hs = wb.alu_valid && wb.alu_ready;
            ld_hs  = wb.ld_valid && wb.ld_ready;
            if (alu_hs) n_acc++;
            if (ld_hs) n_acc++;
        end
        idle();
        repeat (8) cyc();
        @(negedge clk);
        n_checks++;
        if (alu_q.size() != 0 || ld_q.size() != 0 || wb.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain: got alu_q=%0d ld_q=%0d busy=%b required 0 0 0",
                     alu_q.size(), ld_q.size(), wb.busy);
        end
        n_checks++;
        if (n_acc < 1000) begin
            n_fail++;
            $display("FAIL rand_traffic: got %0d accepted required >= 1000", n_acc);
        end
    endtask

    initial begin
        idle();
        rst = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_pending();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
